// File: rtl/uart_pkg.sv
// Shared UART definitions: frame width and receiver state encoding.
// The transmitter will pick these up when it moves to enum-based states.
`ifndef UART_DIV
`define UART_DIV 16
`endif

package uart_pkg;

  localparam int UART_BITS = 8;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd3,
    BRK   = 3'd4
  } uart_rx_state_e;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for one asynchronous input bit.
// INIT is the value both flops take in reset, so an idle-high line reads idle immediately.
module sync_2ff #(
  parameter logic INIT = 1'b1
) (
  input  logic clk_i,
  input  logic srst_i,
  input  logic d_i,
  output logic q_o
);

  logic r_meta;
  logic r_sync;

  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      r_meta <= INIT;
      r_sync <= INIT;
    end else begin
      r_meta <= d_i;
      r_sync <= r_meta;
    end
  end

  assign q_o = r_sync;

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: mid-bit sampling from a half-bit start check, one-byte holding
// register on a valid/ready port, single-cycle frame_err_o and overrun_o pulses.
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLKDIV = `UART_DIV
) (
  input  logic                 clk_i,
  input  logic                 srst_i,
  input  logic                 uart_rx_i,
  output logic                 out_val_o,
  output logic [UART_BITS-1:0] out_data_o,
  input  logic                 out_rdy_i,
  output logic                 frame_err_o,
  output logic                 overrun_o,
  output logic                 busy_o
);

  localparam int DIV_W = $clog2(CLKDIV);
  localparam int CNT_W = $clog2(UART_BITS);

  localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(CLKDIV / 2 - 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLKDIV - 1);
  localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(UART_BITS - 1);

  localparam logic [2:0] ST_IDLE  = 3'(IDLE);
  localparam logic [2:0] ST_START = 3'(START);
  localparam logic [2:0] ST_DATA  = 3'(DATA);
  localparam logic [2:0] ST_STOP  = 3'(STOP);
  localparam logic [2:0] ST_BRK   = 3'(BRK);

  logic [2:0]           r_state;
  logic [DIV_W-1:0]     r_div;
  logic [CNT_W-1:0]     r_bit_cnt;
  logic [UART_BITS-1:0] r_shift;
  logic                 r_val;
  logic [UART_BITS-1:0] r_data;
  logic                 r_frame_err;
  logic                 r_overrun;

  logic                 w_rx_s;
  logic                 w_stop_sample;
  logic                 w_deliver;
  logic                 w_accept;
  uart_rx_state_e       w_dbg_state;

  sync_2ff #(
    .INIT (1'b1)
  ) u_sync (
    .clk_i  (clk_i),
    .srst_i (srst_i),
    .d_i    (uart_rx_i),
    .q_o    (w_rx_s)
  );

  // Handshake: a byte moves on any edge where out_val_o & out_rdy_i; out_data_o is
  // frozen while out_val_o is high and no transfer occurs; out_rdy_i is ignored when idle.
  assign w_stop_sample = (r_state == ST_STOP) && (r_div == DIV_LAST);
  assign w_deliver     = w_stop_sample && w_rx_s;
  assign w_accept      = r_val && out_rdy_i;

  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      r_state     <= ST_IDLE;
      r_div       <= '0;
      r_bit_cnt   <= '0;
      r_shift     <= '0;
      r_val       <= 1'b0;
      r_data      <= '0;
      r_frame_err <= 1'b0;
      r_overrun   <= 1'b0;
    end else begin
      r_frame_err <= 1'b0;
      r_overrun   <= 1'b0;

      if (w_accept) begin
        r_val <= 1'b0;
      end
      // A finished byte may replace the held one only if the host takes it this cycle.
      if (w_deliver) begin
        if (!r_val || out_rdy_i) begin
          r_data <= r_shift;
          r_val  <= 1'b1;
        end else begin
          r_overrun <= 1'b1;
        end
      end

      case (r_state)
        ST_IDLE: begin
          r_div <= '0;
          if (!w_rx_s) begin
            r_state <= ST_START;
          end
        end
        ST_START: begin
          if (r_div == DIV_HALF) begin
            r_div <= '0;
            if (!w_rx_s) begin
              r_state   <= ST_DATA;
              r_bit_cnt <= '0;
            end else begin
              r_state <= ST_IDLE;
            end
          end else begin
            r_div <= r_div + 1'b1;
          end
        end
        ST_DATA: begin
          if (r_div == DIV_LAST) begin
            r_div     <= '0;
            r_shift   <= {w_rx_s, r_shift[UART_BITS-1:1]};
            r_bit_cnt <= r_bit_cnt + 1'b1;
            if (r_bit_cnt == BIT_LAST) begin
              r_state <= ST_STOP;
            end
          end else begin
            r_div <= r_div + 1'b1;
          end
        end
        ST_STOP: begin
          if (r_div == DIV_LAST) begin
            r_div <= '0;
            if (w_rx_s) begin
              r_state <= ST_IDLE;
            end else begin
              r_frame_err <= 1'b1;
              r_state     <= ST_BRK;
            end
          end else begin
            r_div <= r_div + 1'b1;
          end
        end
        // A held-low line reports once, then waits for the line to return high.
        ST_BRK: begin
          r_div <= '0;
          if (w_rx_s) begin
            r_state <= ST_IDLE;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_div   <= '0;
        end
      endcase
    end
  end

  // Typed view of the state for probes; busy_o is derived from it.
  assign w_dbg_state = uart_rx_state_e'(r_state);

  assign out_val_o   = r_val;
  assign out_data_o  = r_data;
  assign frame_err_o = r_frame_err;
  assign overrun_o   = r_overrun;
  assign busy_o      = (w_dbg_state != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx at CLKDIV=16: framing, glitch rejection, break,
// overrun, ready/delivery coincidence and mid-frame reset.
module tb_uart_rx;

  logic       clk_i = 1'b0;
  logic       srst_i = 1'b1;
  logic       uart_rx_i = 1'b1;
  logic       out_val_o;
  logic [7:0] out_data_o;
  logic       out_rdy_i = 1'b0;
  logic       frame_err_o;
  logic       overrun_o;
  logic       busy_o;

  int n_vec = 0;
  int n_err = 0;

  uart_rx #(
    .CLKDIV (16)
  ) dut (
    .clk_i       (clk_i),
    .srst_i      (srst_i),
    .uart_rx_i   (uart_rx_i),
    .out_val_o   (out_val_o),
    .out_data_o  (out_data_o),
    .out_rdy_i   (out_rdy_i),
    .frame_err_o (frame_err_o),
    .overrun_o   (overrun_o),
    .busy_o      (busy_o)
  );

  // Clock and cycle counter
  always #5 clk_i = ~clk_i;

  int cyc = 0;
  always @(posedge clk_i) cyc <= cyc + 1;

  // Output monitor, sampled on the falling edge
  int         val_rises = 0;
  int         val_hi = 0;
  int         fe_cnt = 0;
  int         ov_cnt = 0;
  int         busy_hi = 0;
  int         rise_cyc = 0;
  logic [7:0] rise_data = 8'h00;
  logic       prev_val = 1'b0;

  always @(negedge clk_i) begin
    if (out_val_o === 1'b1 && prev_val !== 1'b1) begin
      val_rises = val_rises + 1;
      rise_cyc  = cyc;
      rise_data = out_data_o;
    end
    if (out_val_o === 1'b1) val_hi = val_hi + 1;
    if (frame_err_o === 1'b1) fe_cnt = fe_cnt + 1;
    if (overrun_o === 1'b1) ov_cnt = ov_cnt + 1;
    if (busy_o === 1'b1) busy_hi = busy_hi + 1;
    prev_val = out_val_o;
  end

  // Driver: called #1 after a posedge; the next posedge is the first to see the start bit.
  // Returns #1 after the last posedge of the stop bit with the line still at stop_bit.
  task automatic drive_frame(input logic [7:0] d, input logic stop_bit);
    uart_rx_i = 1'b0;
    for (int i = 0; i < 8; i++) begin
      repeat (16) @(posedge clk_i);
      #1 uart_rx_i = d[i];
    end
    repeat (16) @(posedge clk_i);
    #1 uart_rx_i = stop_bit;
    repeat (16) @(posedge clk_i);
    #1;
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) @(posedge clk_i);
    #1;
  endtask

  task automatic test_reset;
    srst_i = 1'b1;
    uart_rx_i = 1'b1;
    out_rdy_i = 1'b0;
    repeat (3) @(posedge clk_i);
    #1 srst_i = 1'b0;
    @(negedge clk_i);
    n_vec++;
    if ({out_val_o, out_data_o, frame_err_o, overrun_o, busy_o} !== 12'h000) begin
      n_err++;
      $display("FAIL reset_outputs: val=%b data=%h fe=%b ov=%b busy=%b, want all 0",
               out_val_o, out_data_o, frame_err_o, overrun_o, busy_o);
    end
    idle_cycles(4);
    n_vec++;
    if (busy_o !== 1'b0) begin
      n_err++;
      $display("FAIL reset_idle_busy: busy=%b, want 0", busy_o);
    end
  endtask

  task automatic test_single_frame;
    int start_c, r0, h0, f0;
    out_rdy_i = 1'b1;
    r0 = val_rises; h0 = val_hi; f0 = fe_cnt;
    start_c = cyc + 1;
    drive_frame(8'hA5, 1'b1);
    idle_cycles(4);
    n_vec++;
    if (val_rises - r0 !== 1) begin
      n_err++;
      $display("FAIL a5_deliveries: got %0d, want 1", val_rises - r0);
    end
    n_vec++;
    if (rise_data !== 8'hA5) begin
      n_err++;
      $display("FAIL a5_data: got %h, want a5", rise_data);
    end
    n_vec++;
    if (rise_cyc - start_c < 153 || rise_cyc - start_c > 155) begin
      n_err++;
      $display("FAIL a5_latency: got %0d, want 154+/-1", rise_cyc - start_c);
    end
    n_vec++;
    if (val_hi - h0 !== 1) begin
      n_err++;
      $display("FAIL a5_val_width: got %0d cycles, want 1", val_hi - h0);
    end
    n_vec++;
    if (fe_cnt - f0 !== 0) begin
      n_err++;
      $display("FAIL a5_frame_err: got %0d pulses, want 0", fe_cnt - f0);
    end
  endtask

  task automatic test_glitch;
    int r0, f0, b0;
    r0 = val_rises; f0 = fe_cnt; b0 = busy_hi;
    uart_rx_i = 1'b0;
    repeat (6) @(posedge clk_i);
    #1 uart_rx_i = 1'b1;
    repeat (6) @(posedge clk_i);
    @(negedge clk_i);
    n_vec++;
    if (busy_o !== 1'b0) begin
      n_err++;
      $display("FAIL glitch_busy_c11: busy=%b, want 0", busy_o);
    end
    n_vec++;
    if (busy_hi - b0 !== 8) begin
      n_err++;
      $display("FAIL glitch_busy_len: got %0d cycles, want 8", busy_hi - b0);
    end
    idle_cycles(40);
    n_vec++;
    if (val_rises - r0 !== 0 || fe_cnt - f0 !== 0) begin
      n_err++;
      $display("FAIL glitch_no_event: rises=%0d fe=%0d, want 0 0", val_rises - r0, fe_cnt - f0);
    end
  endtask

  task automatic test_break;
    int r0, f0;
    out_rdy_i = 1'b1;
    r0 = val_rises; f0 = fe_cnt;
    drive_frame(8'h3C, 1'b0);
    @(negedge clk_i);
    n_vec++;
    if (busy_o !== 1'b1) begin
      n_err++;
      $display("FAIL break_busy: busy=%b, want 1", busy_o);
    end
    @(posedge clk_i);
    #1;
    idle_cycles(39);
    uart_rx_i = 1'b1;
    idle_cycles(10);
    n_vec++;
    if (fe_cnt - f0 !== 1) begin
      n_err++;
      $display("FAIL break_frame_err: got %0d pulses, want 1", fe_cnt - f0);
    end
    n_vec++;
    if (val_rises - r0 !== 0) begin
      n_err++;
      $display("FAIL break_no_val: got %0d deliveries, want 0", val_rises - r0);
    end
    n_vec++;
    if (busy_o !== 1'b0) begin
      n_err++;
      $display("FAIL break_release: busy=%b, want 0", busy_o);
    end
    r0 = val_rises; f0 = fe_cnt;
    drive_frame(8'h81, 1'b1);
    idle_cycles(4);
    n_vec++;
    if (val_rises - r0 !== 1 || rise_data !== 8'h81) begin
      n_err++;
      $display("FAIL after_break_81: rises=%0d data=%h, want 1 81", val_rises - r0, rise_data);
    end
    n_vec++;
    if (fe_cnt - f0 !== 0) begin
      n_err++;
      $display("FAIL after_break_fe: got %0d, want 0", fe_cnt - f0);
    end
  endtask

  task automatic test_overrun;
    int r0, o0;
    out_rdy_i = 1'b0;
    r0 = val_rises; o0 = ov_cnt;
    drive_frame(8'h11, 1'b1);
    drive_frame(8'h22, 1'b1);
    idle_cycles(4);
    @(negedge clk_i);
    n_vec++;
    if (out_val_o !== 1'b1 || out_data_o !== 8'h11) begin
      n_err++;
      $display("FAIL overrun_hold: val=%b data=%h, want 1 11", out_val_o, out_data_o);
    end
    n_vec++;
    if (ov_cnt - o0 !== 1) begin
      n_err++;
      $display("FAIL overrun_pulse: got %0d cycles, want 1", ov_cnt - o0);
    end
    n_vec++;
    if (val_rises - r0 !== 1) begin
      n_err++;
      $display("FAIL overrun_rises: got %0d, want 1", val_rises - r0);
    end
    @(posedge clk_i);
    #1 out_rdy_i = 1'b1;
    @(posedge clk_i);
    #1 out_rdy_i = 1'b0;
    @(negedge clk_i);
    n_vec++;
    if (out_val_o !== 1'b0) begin
      n_err++;
      $display("FAIL overrun_drain: val=%b, want 0", out_val_o);
    end
    @(posedge clk_i);
    #1;
  endtask

  task automatic test_ready_coincide;
    int o0;
    out_rdy_i = 1'b0;
    drive_frame(8'h55, 1'b1);
    idle_cycles(8);
    @(negedge clk_i);
    n_vec++;
    if (out_val_o !== 1'b1 || out_data_o !== 8'h55) begin
      n_err++;
      $display("FAIL coincide_hold55: val=%b data=%h, want 1 55", out_val_o, out_data_o);
    end
    @(posedge clk_i);
    #1;
    o0 = ov_cnt;
    fork
      drive_frame(8'h66, 1'b1);
      begin
        repeat (154) @(posedge clk_i);
        #1 out_rdy_i = 1'b1;
        @(negedge clk_i);
        n_vec++;
        if (out_val_o !== 1'b1 || out_data_o !== 8'h55) begin
          n_err++;
          $display("FAIL coincide_pre: val=%b data=%h, want 1 55", out_val_o, out_data_o);
        end
        @(posedge clk_i);
        #1 out_rdy_i = 1'b0;
        @(negedge clk_i);
        n_vec++;
        if (out_val_o !== 1'b1 || out_data_o !== 8'h66) begin
          n_err++;
          $display("FAIL coincide_post: val=%b data=%h, want 1 66", out_val_o, out_data_o);
        end
      end
    join
    n_vec++;
    if (ov_cnt - o0 !== 0) begin
      n_err++;
      $display("FAIL coincide_overrun: got %0d pulses, want 0", ov_cnt - o0);
    end
  endtask

  task automatic test_reset_midframe;
    int r0;
    n_vec++;
    if (out_val_o !== 1'b1 || out_data_o !== 8'h66) begin
      n_err++;
      $display("FAIL midreset_pre: val=%b data=%h, want 1 66", out_val_o, out_data_o);
    end
    r0 = 0;
    fork
      drive_frame(8'hF0, 1'b1);
      begin
        repeat (88) @(posedge clk_i);
        #1 srst_i = 1'b1;
        @(posedge clk_i);
        #1 srst_i = 1'b0;
        @(negedge clk_i);
        n_vec++;
        if ({out_val_o, out_data_o, frame_err_o, overrun_o, busy_o} !== 12'h000) begin
          n_err++;
          $display("FAIL midreset_outputs: val=%b data=%h fe=%b ov=%b busy=%b, want all 0",
                   out_val_o, out_data_o, frame_err_o, overrun_o, busy_o);
        end
        r0 = val_rises;
      end
    join
    idle_cycles(20);
    n_vec++;
    if (val_rises - r0 !== 0 || busy_o !== 1'b0) begin
      n_err++;
      $display("FAIL midreset_no_delivery: rises=%0d busy=%b, want 0 0", val_rises - r0, busy_o);
    end
    out_rdy_i = 1'b1;
    r0 = val_rises;
    drive_frame(8'h0F, 1'b1);
    idle_cycles(4);
    n_vec++;
    if (val_rises - r0 !== 1 || rise_data !== 8'h0F) begin
      n_err++;
      $display("FAIL midreset_0f: rises=%0d data=%h, want 1 0f", val_rises - r0, rise_data);
    end
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_glitch();
    test_break();
    test_overrun();
    test_ready_coincide();
    test_reset_midframe();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
